// File: rtl/interrupt_interface_unit.sv
// Machine-mode interrupt front end: latches ext/sw/timer requests, merges them into mip, picks the taken interrupt.
// Optional macro INTIF_REQ_SYNC_EN adds a 2-flop synchronizer on each request input.
module interrupt_interface_unit #(
    parameter int unsigned REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      all_intif_int_ext_req,
    input  logic                      all_intif_int_software_req,
    input  logic                      all_intif_int_timer_req,
    output logic                      intif_all_int_ext_ack,
    output logic                      intif_all_int_software_ack,
    output logic                      intif_all_int_timer_ack,
    input  logic [REG_DATA_WIDTH-1:0] csrf_all_mie_data,
    input  logic [REG_DATA_WIDTH-1:0] csrf_all_mstatus_data,
    input  logic [REG_DATA_WIDTH-1:0] csrf_all_mip_data,
    output logic [REG_DATA_WIDTH-1:0] intif_csrf_mip_data,
    output logic                      intif_commit_has_interrupt,
    output logic [REG_DATA_WIDTH-1:0] intif_commit_mcause_data,
    output logic [REG_DATA_WIDTH-1:0] intif_commit_ack_data,
    input  logic [REG_DATA_WIDTH-1:0] commit_intif_ack_data
);

    localparam int unsigned MEIP    = 11;
    localparam int unsigned MTIP    = 7;
    localparam int unsigned MSIP    = 3;
    localparam int unsigned MIE_BIT = 3;
    localparam int unsigned CAUSE_W = 5;
    localparam logic [REG_DATA_WIDTH-1:0] INT_MASK =
        (REG_DATA_WIDTH'(1) << MEIP) | (REG_DATA_WIDTH'(1) << MTIP) | (REG_DATA_WIDTH'(1) << MSIP);

    // Request vector order: {ext, software, timer}
    logic [2:0] req_raw;
    logic [2:0] req_eff;

    logic pend_e_q, pend_e_d;
    logic pend_s_q, pend_s_d;
    logic pend_t_q, pend_t_d;

    logic [REG_DATA_WIDTH-1:0] mip_out;
    logic [REG_DATA_WIDTH-1:0] active;
    logic [CAUSE_W-1:0]        cause;
    logic                      has_int;
    logic [REG_DATA_WIDTH-1:0] mcause;
    logic [REG_DATA_WIDTH-1:0] ack_onehot;
    logic                      unused_bits;

    assign req_raw = {all_intif_int_ext_req, all_intif_int_software_req, all_intif_int_timer_req};

`ifdef INTIF_REQ_SYNC_EN
    logic [2:0] req_sync1_q, req_sync1_d;
    logic [2:0] req_sync2_q, req_sync2_d;

    always_comb begin
        req_sync1_d = req_raw;
        req_sync2_d = req_sync1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync1_q <= '0;
            req_sync2_q <= '0;
        end else begin
            req_sync1_q <= req_sync1_d;
            req_sync2_q <= req_sync2_d;
        end
    end

    assign req_eff = req_sync2_q;
`else
    assign req_eff = req_raw;
`endif

    // Pending update; a same-cycle request overrides the commit clear
    always_comb begin
        pend_e_d = req_eff[2] | (pend_e_q & ~commit_intif_ack_data[MEIP]);
        pend_s_d = req_eff[1] | (pend_s_q & ~commit_intif_ack_data[MSIP]);
        pend_t_d = req_eff[0] | (pend_t_q & ~commit_intif_ack_data[MTIP]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_e_q <= 1'b0;
            pend_s_q <= 1'b0;
            pend_t_q <= 1'b0;
        end else begin
            pend_e_q <= pend_e_d;
            pend_s_q <= pend_s_d;
            pend_t_q <= pend_t_d;
        end
    end

    // mip merge and taken-interrupt selection (MEI > MSI > MTI)
    always_comb begin
        mip_out       = csrf_all_mip_data;
        mip_out[MEIP] = pend_e_q;
        mip_out[MSIP] = pend_s_q;
        mip_out[MTIP] = pend_t_q;

        active  = mip_out & csrf_all_mie_data & INT_MASK;
        has_int = csrf_all_mstatus_data[MIE_BIT] & (|active);

        cause = '0;
        if (active[MEIP]) begin
            cause = CAUSE_W'(MEIP);
        end else if (active[MSIP]) begin
            cause = CAUSE_W'(MSIP);
        end else if (active[MTIP]) begin
            cause = CAUSE_W'(MTIP);
        end

        mcause     = '0;
        ack_onehot = '0;
        if (has_int) begin
            mcause                     = REG_DATA_WIDTH'(cause);
            mcause[REG_DATA_WIDTH-1]   = 1'b1;
            ack_onehot                 = REG_DATA_WIDTH'(1) << cause;
        end
    end

    assign intif_csrf_mip_data        = mip_out;
    assign intif_commit_has_interrupt = has_int;
    assign intif_commit_mcause_data   = mcause;
    assign intif_commit_ack_data      = ack_onehot;

    assign intif_all_int_ext_ack      = commit_intif_ack_data[MEIP];
    assign intif_all_int_software_ack = commit_intif_ack_data[MSIP];
    assign intif_all_int_timer_ack    = commit_intif_ack_data[MTIP];

    // Only a few bits of mstatus and the commit mask are meaningful here
    assign unused_bits = ^{csrf_all_mstatus_data, commit_intif_ack_data};

endmodule

// File: tb/tb_interrupt_interface_unit.sv
// Directed self-checking bench for interrupt_interface_unit; expected values are hand-computed.
module tb_interrupt_interface_unit;

`ifdef INTIF_REQ_SYNC_EN
    localparam int unsigned REQ_LAT = 3;
`else
    localparam int unsigned REQ_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic        req_e, req_s, req_t;
    logic        ack_e, ack_s, ack_t;
    logic [31:0] mie, mstatus, mip_in, mip_out;
    logic        has_int;
    logic [31:0] mcause, ack_data, commit_ack;

    int errors = 0;
    int checks = 0;

    interrupt_interface_unit #(.REG_DATA_WIDTH(32)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .all_intif_int_ext_req      (req_e),
        .all_intif_int_software_req (req_s),
        .all_intif_int_timer_req    (req_t),
        .intif_all_int_ext_ack      (ack_e),
        .intif_all_int_software_ack (ack_s),
        .intif_all_int_timer_ack    (ack_t),
        .csrf_all_mie_data          (mie),
        .csrf_all_mstatus_data      (mstatus),
        .csrf_all_mip_data          (mip_in),
        .intif_csrf_mip_data        (mip_out),
        .intif_commit_has_interrupt (has_int),
        .intif_commit_mcause_data   (mcause),
        .intif_commit_ack_data      (ack_data),
        .commit_intif_ack_data      (commit_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, inputs change 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic steps(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step();
    endtask

    initial begin
        rst = 1'b0;
        req_e = 1'b0; req_s = 1'b0; req_t = 1'b0;
        mie = '0; mstatus = '0; mip_in = '0; commit_ack = '0;

        // Reset holds pending clear even with a request present
        req_t = 1'b1;
        steps(3);
        settle();
        check("rst_mip", mip_out, 32'h0);
        check("rst_has_int", {31'b0, has_int}, 32'h0);
        check("rst_acks", {29'b0, ack_e, ack_s, ack_t}, 32'h0);
        check("rst_mcause", mcause, 32'h0);
        check("rst_ack_data", ack_data, 32'h0);
        req_t = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Timer pulse, enabled
        mie = 32'h80; mstatus = 32'h8;
        req_t = 1'b1;
        settle();
        check("tmr_before_edge", mip_out, 32'h0);
        step();
        req_t = 1'b0;
        steps(REQ_LAT - 1);
        settle();
        check("tmr_mip", mip_out, 32'h80);
        check("tmr_has_int", {31'b0, has_int}, 32'h1);
        check("tmr_mcause", mcause, 32'h8000_0007);
        check("tmr_ack_data", ack_data, 32'h80);

        // Ext + timer pending: ext has priority, then commit clears ext
        mie = 32'h888;
        step();
        req_e = 1'b1;
        step();
        req_e = 1'b0;
        steps(REQ_LAT - 1);
        settle();
        check("et_mcause", mcause, 32'h8000_000B);
        check("et_ack_data", ack_data, 32'h800);
        step();
        commit_ack = 32'h800;
        settle();
        check("et_commit_acks", {29'b0, ack_e, ack_s, ack_t}, 32'h4);
        check("et_commit_mcause", mcause, 32'h8000_000B);
        step();
        commit_ack = '0;
        settle();
        check("et_after_acks", {29'b0, ack_e, ack_s, ack_t}, 32'h0);
        check("et_after_mcause", mcause, 32'h8000_0007);
        check("et_after_mip", mip_out, 32'h80);
        step();
        commit_ack = 32'h80;
        settle();
        check("t_commit_acks", {29'b0, ack_e, ack_s, ack_t}, 32'h1);
        step();
        commit_ack = '0;
        settle();
        check("t_cleared_has", {31'b0, has_int}, 32'h0);
        check("t_cleared_mcause", mcause, 32'h0);
        check("t_cleared_ack_data", ack_data, 32'h0);

        // Software pending with global MIE off, then on
        mstatus = 32'h0;
        req_s = 1'b1;
        step();
        req_s = 1'b0;
        steps(REQ_LAT - 1);
        settle();
        check("sw_mie0_has", {31'b0, has_int}, 32'h0);
        check("sw_mie0_mip", mip_out, 32'h8);
        check("sw_mie0_mcause", mcause, 32'h0);
        step();
        mstatus = 32'h8;
        settle();
        check("sw_mie1_has", {31'b0, has_int}, 32'h1);
        check("sw_mie1_mcause", mcause, 32'h8000_0003);
        check("sw_mie1_ack_data", ack_data, 32'h8);

        // MSI beats MTI; masked ext stays pending until its mie bit is set
        step();
        req_t = 1'b1;
        mie = 32'h088;
        step();
        req_t = 1'b0;
        req_e = 1'b1;
        step();
        req_e = 1'b0;
        steps(REQ_LAT);
        settle();
        check("prio_sw_mcause", mcause, 32'h8000_0003);
        check("prio_mip", mip_out, 32'h888);
        step();
        mie = 32'h888;
        settle();
        check("prio_ext_en_mcause", mcause, 32'h8000_000B);
        step();
        commit_ack = 32'h888;
        settle();
        check("all_acks", {29'b0, ack_e, ack_s, ack_t}, 32'h7);
        step();
        commit_ack = '0;
        settle();
        check("all_cleared_mip", mip_out, 32'h0);
        check("all_cleared_has", {31'b0, has_int}, 32'h0);

        // Held software request wins over a same-cycle commit clear
        step();
        req_s = 1'b1;
        steps(REQ_LAT);
        commit_ack = 32'h8;
        settle();
        check("hold_sw_ack", {29'b0, ack_e, ack_s, ack_t}, 32'h2);
        step();
        commit_ack = '0;
        settle();
        check("hold_sw_pending", mip_out, 32'h8);
        req_s = 1'b0;
        steps(REQ_LAT + 1);

        // Commit bits outside the interrupt mask are ignored
        commit_ack = 32'hFFFF_F777;
        settle();
        check("oob_acks", {29'b0, ack_e, ack_s, ack_t}, 32'h0);
        step();
        commit_ack = '0;
        settle();
        check("oob_sw_kept", mip_out, 32'h8);
        step();
        commit_ack = 32'h8;
        step();
        commit_ack = '0;

        // Non-interrupt mip bits pass through
        mip_in = 32'hFFFF_FFFF;
        settle();
        check("mip_passthru", mip_out, 32'hFFFF_F777);
        check("mip_passthru_has", {31'b0, has_int}, 32'h0);

        // Asynchronous reset mid-run clears pending immediately
        mip_in = '0;
        step();
        req_t = 1'b1;
        steps(REQ_LAT);
        req_t = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mip", mip_out, 32'h0);
        step();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/interrupt_interface_unit.md
Name: interrupt_interface_unit

Overview:
Machine-mode interrupt front end for the RISC-V core. It latches external, software and timer interrupt requests into pending bits and merges them into the mip value written back to the CSR file. It evaluates mie/mstatus.MIE to tell commit that an interrupt must be taken, with mcause and a one-hot ack mask. Commit returns that mask to clear pending state and acknowledge the source.

Parameters:
REG_DATA_WIDTH, 32, CSR data width; bit indices MEIP=11, MTIP=7, MSIP=3, mstatus.MIE=3.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
all_intif_int_ext_req  in  1  external interrupt request (level)
all_intif_int_software_req  in  1  software interrupt request (level)
all_intif_int_timer_req  in  1  timer interrupt request (level)
intif_all_int_ext_ack  out  1  external interrupt acknowledge
intif_all_int_software_ack  out  1  software interrupt acknowledge
intif_all_int_timer_ack  out  1  timer interrupt acknowledge
csrf_all_mie_data  in  REG_DATA_WIDTH  current mie
csrf_all_mstatus_data  in  REG_DATA_WIDTH  current mstatus
csrf_all_mip_data  in  REG_DATA_WIDTH  current mip
intif_csrf_mip_data  out  REG_DATA_WIDTH  mip value to write back
intif_commit_has_interrupt  out  1  interrupt must be taken
intif_commit_mcause_data  out  REG_DATA_WIDTH  mcause for the taken interrupt
intif_commit_ack_data  out  REG_DATA_WIDTH  one-hot mip bit of the taken interrupt
commit_intif_ack_data  in  REG_DATA_WIDTH  mip-bit mask commit has serviced this cycle

Behaviour:
- State: three pending flops, pend_e/pend_s/pend_t. Reset (rst=0) clears all three immediately.
- Update each clk: pend_x <= req_x | (pend_x & ~ack_bit_x), where ack_bit_x is commit_intif_ack_data at MEIP/MSIP/MTIP. If a request and its ack occur in the same cycle, the request wins.
- Request-to-pending latency is 1 cycle. All other outputs are combinational from the pending flops and the current inputs.
- intif_csrf_mip_data = csrf_all_mip_data with bits 11/3/7 replaced by pend_e/pend_s/pend_t. All other bits pass through unchanged.
- active = mip_out & csrf_all_mie_data & int_mask, where int_mask has only bits 11, 7 and 3 set.
- intif_commit_has_interrupt = mstatus[3] & |active.
- Priority when several bits are active: MEI, then MSI, then MTI.
- intif_commit_mcause_data = {1'b1, zero-extended cause}, with cause 11, 3 or 7 respectively.
- intif_commit_ack_data = 1 << cause.
- When has_interrupt=0, mcause and ack_data are 0.
- Source acks: intif_all_int_ext_ack = commit_intif_ack_data[11], software_ack = [3], timer_ack = [7]. These are combinational, same cycle, and single-cycle per commit pulse.
- Commit ack bits outside int_mask are ignored.
- Reset outputs: all acks 0; has_interrupt 0; mcause 0; ack_data 0; mip_out equals csrf_all_mip_data with bits 11/7/3 cleared.
- An interrupt pending while MIE=0 or its mie bit=0 stays pending and is taken once it becomes enabled.

Optional Feature:
INTIF_REQ_SYNC_EN:
- Defined: each of the three request inputs passes through a 2-flop synchronizer (reset to 0) before the pending logic, giving 3 cycles request-to-pending latency.
- Undefined: requests feed the pending logic directly, giving 1 cycle latency.
- Ack and commit paths are unchanged either way.

Test Plan:
- Reset, all inputs 0 -> has_interrupt=0, all acks 0, mip_out=0.
- Timer req=1 for 1 cycle, mie=0x80, mstatus=0x8 -> next cycle mip_out bit7=1, has_interrupt=1, mcause=0x80000007, ack_data=0x80.
- Ext and timer pending, mie=0x888, MIE=1 -> mcause=0x8000000B, ack_data=0x800. After commit_ack=0x800 for one cycle: ext_ack=1 that cycle, next cycle mcause=0x80000007.
- Software pending with mstatus=0 -> has_interrupt=0 and mip bit3=1. Then set mstatus=0x8 -> has_interrupt=1, mcause=0x80000003.
- Software req held high while commit_ack=0x8 -> software_ack=1 and pend_s stays 1 (request wins).
- csrf_all_mip_data=0xFFFFFFFF with nothing pending -> mip_out=0xFFFFF777.
